// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES-256 CTR-mode round sequencer.
package aes_pkg;

   localparam int unsigned NR_DEF    = 14;
   localparam int unsigned CTR_W_DEF = 32;
   localparam int unsigned BLK_W     = 128;
   localparam int unsigned RND_IDX_W = 4;

   typedef logic [BLK_W-1:0]     blk_t;
   typedef logic [RND_IDX_W-1:0] rnd_idx_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_KEYX  = 3'd1,
      ST_READY = 3'd2,
      ST_ROUND = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   // Control outputs registered next to the state, kept together as one flop group.
   typedef struct packed {
      logic     kx_start;
      logic     ready;
      logic     rnd_start;
      rnd_idx_t rnd_idx;
      logic     rnd_last;
      logic     out_valid;
      logic     key_ready;
      logic     busy;
      logic     err_nokey;
   } ctl_out_t;

   function automatic logic state_busy(input state_t s);
      return (s == ST_KEYX) || (s == ST_ROUND) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/aes256_ctr_ctrl_if.sv
// Handshake and data bundle between the CTR sequencer and its host / datapath.
interface aes256_ctr_ctrl_if;
   import aes_pkg::*;

   logic     key_load;
   logic     kx_start;
   logic     kx_done;
   logic     iv_load;
   blk_t     iv;
   logic     blk_valid;
   logic     blk_ready;
   logic     rnd_start;
   rnd_idx_t rnd_idx;
   logic     rnd_last;
   blk_t     ctr_out;
   logic     out_valid;
   logic     out_ready;
   logic     key_ready;
   logic     busy;
   logic     err_nokey;

   modport master (
      output key_load, kx_done, iv_load, iv, blk_valid, out_ready,
      input  kx_start, blk_ready, rnd_start, rnd_idx, rnd_last, ctr_out,
             out_valid, key_ready, busy, err_nokey
   );

   modport slave (
      input  key_load, kx_done, iv_load, iv, blk_valid, out_ready,
      output kx_start, blk_ready, rnd_start, rnd_idx, rnd_last, ctr_out,
             out_valid, key_ready, busy, err_nokey
   );

endinterface

// File: rtl/ctr_inc.sv
// Counter-block increment: low CTR_W bits wrap modulo 2^CTR_W, upper bits pass through.
module ctr_inc
   import aes_pkg::*;
#(
   parameter int unsigned CTR_W = CTR_W_DEF
) (
   input  blk_t blk,
   output blk_t blk_inc
);

   generate
      if (CTR_W >= BLK_W) begin : g_full
         assign blk_inc = blk + BLK_W'(1);
      end else begin : g_part
         assign blk_inc = {blk[BLK_W-1:CTR_W], blk[CTR_W-1:0] + CTR_W'(1)};
      end
   endgenerate

endmodule

// File: rtl/aes256_ctr_ctrl.sv
// Sequences key expansion and the AES-256 round datapath for CTR-mode keystream blocks.
module aes256_ctr_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NR    = NR_DEF,
   parameter int unsigned CTR_W = CTR_W_DEF
) (
   input logic              clk,
   input logic              rst,
   aes256_ctr_ctrl_if.slave bus
);

   localparam rnd_idx_t LAST_IDX = RND_IDX_W'(NR);

   state_t   state_q, state_d;
   logic     pend_q, pend_d;
   blk_t     ctr_q, ctr_d, ctr_nxt;
   ctl_out_t out_q, out_d;
   logic     accept;
   logic     iv_ok;

   ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
      .blk     (ctr_q),
      .blk_inc (ctr_nxt)
   );

   // State, pending-rekey flag, counter block and registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
         ctr_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ctr_q   <= ctr_d;
         out_q   <= out_d;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      ctr_d   = ctr_q;
      out_d   = '0;
      // A fresh key request always beats a block request in READY.
      accept  = (state_q == ST_READY) && bus.blk_valid && !bus.key_load;
      iv_ok   = (state_q == ST_IDLE) || (state_q == ST_KEYX) || (state_q == ST_READY);

      case (state_q)
         ST_IDLE: begin
            if (bus.key_load) state_d = ST_KEYX;
         end
         ST_KEYX: begin
            if (bus.kx_done) state_d = ST_READY;
         end
         ST_READY: begin
            if (bus.key_load)  state_d = ST_KEYX;
            else if (accept)   state_d = ST_ROUND;
         end
         ST_ROUND: begin
            if (bus.key_load)                state_d = state_d;
            if (bus.key_load)                pend_d  = 1'b1;
            if (out_q.rnd_idx == LAST_IDX)   state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.key_load) pend_d = 1'b1;
            if (out_q.out_valid && bus.out_ready) begin
               ctr_d   = ctr_nxt;
               state_d = (pend_q || bus.key_load) ? ST_KEYX : ST_READY;
               pend_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
         end
      endcase

      if (bus.iv_load && iv_ok) ctr_d = bus.iv;

      out_d.kx_start  = (state_d == ST_KEYX) && (state_q != ST_KEYX);
      out_d.ready     = (state_d == ST_READY);
      out_d.rnd_start = (state_d == ST_ROUND);
      out_d.rnd_idx   = ((state_d == ST_ROUND) && (state_q == ST_ROUND)) ?
                        out_q.rnd_idx + RND_IDX_W'(1) : '0;
      out_d.rnd_last  = out_d.rnd_start && (out_d.rnd_idx == LAST_IDX);
      out_d.out_valid = (state_d == ST_HOLD);
      out_d.key_ready = (state_d == ST_READY) || (state_d == ST_ROUND) || (state_d == ST_HOLD);
      out_d.busy      = state_busy(state_d);
      out_d.err_nokey = bus.blk_valid && ((state_q == ST_IDLE) || (state_q == ST_KEYX));
   end

   assign bus.kx_start  = out_q.kx_start;
   assign bus.blk_ready = out_q.ready && !bus.key_load;
   assign bus.rnd_start = out_q.rnd_start;
   assign bus.rnd_idx   = out_q.rnd_idx;
   assign bus.rnd_last  = out_q.rnd_last;
   assign bus.ctr_out   = ctr_q;
   assign bus.out_valid = out_q.out_valid;
   assign bus.key_ready = out_q.key_ready;
   assign bus.busy      = out_q.busy;
   assign bus.err_nokey = out_q.err_nokey;

endmodule
